cia_serial_port: RTL and testbench
==================================

# cia_serial_port

CIA serial data register (SDR) controller for the Amiga CIA. Sequences 8-bit shift transfers on the SP/CNT pins. In output mode it consumes Timer A underflow pulses as its bit clock. In input mode it shifts on external CNT rising edges. Sits beside the Timer A block inside each CIA and raises the SP interrupt source to the ICR logic.

## Interface
Parameters: none.

Ports:
- clk  in  1  system clock
- reset  in  1  reset; synchronous, active-high, sampled only when clk7_en=1
- clk7_en  in  1  7 MHz clock enable; all state advances only when high
- wr  in  1  CPU write strobe
- sdr  in  1  SDR register select ($xC)
- data_in  in  8  CPU write data
- data_out  out  8  SDR read data; 0 unless sdr & ~wr
- spmode  in  1  from Timer A CRA bit 6: 1=output, 0=input
- tmra_ovf  in  1  Timer A underflow pulse, one clk7_en cycle wide
- sp_in  in  1  SP pin input
- cnt_in  in  1  CNT pin input
- sp_out  out  1  SP pin drive, valid in output mode
- cnt_out  out  1  CNT pin drive, idles high
- irq  out  1  SP interrupt, one clk7_en-cycle pulse

## Operation
Registers:
- sdr_reg[7:0]: CPU-visible.
- shift[7:0]: shift register.
- bitcnt[3:0]: bit counter.
- pending: output buffer full.
- phase: CNT level in output mode.
- cnt_d: previous cnt_in.
- mode_d: previous spmode.

State machine: IDLE, SHIFT.

Output mode (spmode=1):
- CPU write to SDR: sdr_reg<=data_in, pending<=1.
- In IDLE with pending=1: shift<=sdr_reg, bitcnt<=8, pending<=0, go to SHIFT. Takes 1 clk7_en cycle after the write.
- In SHIFT, each tmra_ovf toggles cnt_out.
  - Toggle 1->0: sp_out<=shift[7], shift<=shift<<1.
  - Toggle 0->1: bitcnt<=bitcnt-1. The receiver samples sp_out on this edge.
- MSB is sent first. 8 bits take 16 underflows.
- On the 0->1 toggle that takes bitcnt to 0: irq pulse.
  - If pending=1: reload shift from sdr_reg, bitcnt<=8, pending<=0, stay in SHIFT. This is back-to-back transmission with no gap.
  - Otherwise go to IDLE, with cnt_out=1 and sp_out holding the last bit.
- SDR write in the same cycle as final-bit completion: the write wins the buffer. pending is set and the new byte is loaded on the next clk7_en cycle from IDLE, not in the completion cycle.

Input mode (spmode=0):
- cnt_out=1 and sp_out=1 throughout.
- Rising edge detected as cnt_in & ~cnt_d, evaluated when clk7_en=1: shift<={shift[6:0],sp_in}, bitcnt<=bitcnt+1.
- When the 8th bit is shifted in: sdr_reg<={shift[6:0],sp_in}, bitcnt<=0, irq pulse.
- CPU writes to SDR in input mode update sdr_reg but do not set pending.

Mode change: spmode != mode_d forces IDLE, bitcnt=0, pending=0, cnt_out=1. shift and sdr_reg are kept. This takes effect in the same cycle and has priority over any tmra_ovf or CNT edge in that cycle.

Read: data_out = sdr_reg when sdr & ~wr, else 8'h00. Reads have no side effects.

## Timing
- Reset values: sdr_reg=0, shift=0, bitcnt=0, pending=0, state=IDLE, cnt_out=1, sp_out=1, irq=0, cnt_d=1, mode_d=0. data_out is 0 unless read-selected.
- irq is registered: high for exactly one clk7_en cycle, the cycle after the completing event.
- tmra_ovf with clk7_en low is ignored. The Timer A block guarantees its underflow pulse is aligned to clk7_en.
- Output latency: write at cycle N gives SHIFT at N+1. The first cnt_out fall occurs on the first tmra_ovf after N+1.
- Reset mid-transfer aborts immediately. No irq is generated.
- tmra_ovf in input mode or in IDLE has no effect.

## Test plan
- Output single byte: spmode=1, write $A5, 16 tmra_ovf pulses -> sp_out sequence on cnt_out rises is 1,0,1,0,0,1,0,1; one irq after pulse 16; state IDLE, cnt_out=1.
- Back-to-back: write $3C, then write $C3 after pulse 4 -> continuous 16 bits $3C,$C3, cnt_out never idles between bytes, two irq pulses 16 underflows apart.
- Input byte: spmode=0, drive 8 cnt_in rising edges with sp_in = bits of $5A, MSB first -> read SDR returns $5A, one irq; drive 7 edges more -> no irq.
- Mode switch abort: output mode, write $FF, 6 pulses, then spmode=0 -> cnt_out=1 same cycle, no irq, pending=0; switch back and write $01 -> full clean transfer of $01.
- Completion collision: write to SDR in the same cycle as pulse 16 of byte $80 -> irq for $80; new byte loaded the next cycle and transmitted in full.
- Reset mid-transfer: reset after pulse 9 -> all outputs at reset values, no irq, SDR reads $00.

Source files
------------

// File: rtl/cia_serial_port.sv
// CIA serial data register controller: 8-bit shift transfers on SP/CNT,
// clocked by Timer A underflows in output mode and by external CNT rises in input mode.
module cia_serial_port (
    input  logic       clk,
    input  logic       reset,
    input  logic       clk7_en,
    input  logic       wr,
    input  logic       sdr,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    input  logic       spmode,
    input  logic       tmra_ovf,
    input  logic       sp_in,
    input  logic       cnt_in,
    output logic       sp_out,
    output logic       cnt_out,
    output logic       irq
);

    localparam int unsigned DATA_W = 8;
    localparam int unsigned CNT_W  = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t              state;
    logic [DATA_W-1:0]   sdr_reg;
    logic [DATA_W-1:0]   shift;
    logic [CNT_W-1:0]    bitcnt;
    logic                pending;
    logic                phase;
    logic                cnt_d;
    logic                mode_d;

    logic                cnt_rise;
    logic                mode_chg;
    logic                cpu_wr;

    assign cnt_rise = cnt_in & ~cnt_d;
    assign mode_chg = spmode != mode_d;
    assign cpu_wr   = sdr & wr;

    // CNT pin level is the output-mode phase register itself.
    assign cnt_out  = phase;

    // Reads are side-effect free and only drive the bus when selected.
    assign data_out = (sdr & ~wr) ? sdr_reg : DATA_W'(0);

    // Whole controller advances on clk7_en; mode change outranks any shift event.
    always_ff @(posedge clk) begin
        if (clk7_en) begin
            if (reset) begin
                state   <= IDLE;
                sdr_reg <= DATA_W'(0);
                shift   <= DATA_W'(0);
                bitcnt  <= CNT_W'(0);
                pending <= 1'b0;
                phase   <= 1'b1;
                sp_out  <= 1'b1;
                irq     <= 1'b0;
                cnt_d   <= 1'b1;
                mode_d  <= 1'b0;
            end else begin
                irq    <= 1'b0;
                cnt_d  <= cnt_in;
                mode_d <= spmode;

                if (mode_chg) begin
                    state   <= IDLE;
                    bitcnt  <= CNT_W'(0);
                    pending <= 1'b0;
                    phase   <= 1'b1;
                    if (!spmode) begin
                        sp_out <= 1'b1;
                    end
                    if (cpu_wr) begin
                        sdr_reg <= data_in;
                    end
                end else if (spmode) begin
                    if (cpu_wr) begin
                        sdr_reg <= data_in;
                    end

                    case (state)
                        IDLE: begin
                            if (pending) begin
                                shift   <= sdr_reg;
                                bitcnt  <= CNT_W'(8);
                                pending <= 1'b0;
                                state   <= SHIFT;
                            end
                        end
                        SHIFT: begin
                            if (tmra_ovf) begin
                                if (phase) begin
                                    // Falling CNT: present next bit, MSB first.
                                    phase  <= 1'b0;
                                    sp_out <= shift[DATA_W-1];
                                    shift  <= {shift[DATA_W-2:0], 1'b0};
                                end else begin
                                    // Rising CNT: receiver samples, bit is complete.
                                    phase  <= 1'b1;
                                    bitcnt <= CNT_W'(bitcnt - CNT_W'(1));
                                    if (bitcnt == CNT_W'(1)) begin
                                        irq <= 1'b1;
                                        if (pending) begin
                                            shift   <= sdr_reg;
                                            bitcnt  <= CNT_W'(8);
                                            pending <= 1'b0;
                                        end else begin
                                            state <= IDLE;
                                        end
                                    end
                                end
                            end
                        end
                        default: state <= IDLE;
                    endcase

                    // A write always claims the buffer, even on a completion cycle.
                    if (cpu_wr) begin
                        pending <= 1'b1;
                    end
                end else begin
                    phase  <= 1'b1;
                    sp_out <= 1'b1;
                    if (cpu_wr) begin
                        sdr_reg <= data_in;
                    end
                    if (cnt_rise) begin
                        shift <= {shift[DATA_W-2:0], sp_in};
                        if (bitcnt == CNT_W'(7)) begin
                            sdr_reg <= {shift[DATA_W-2:0], sp_in};
                            bitcnt  <= CNT_W'(0);
                            irq     <= 1'b1;
                        end else begin
                            bitcnt <= CNT_W'(bitcnt + CNT_W'(1));
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_cia_serial_port.sv
// Bench for cia_serial_port: randomized timer periods, enable gaps and data,
// checked against a pin-level bit-queue model of the serial link.
module tb_cia_serial_port;

    logic       clk = 1'b0;
    logic       reset;
    logic       clk7_en;
    logic       wr;
    logic       sdr;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       spmode;
    logic       tmra_ovf;
    logic       sp_in;
    logic       cnt_in;
    logic       sp_out;
    logic       cnt_out;
    logic       irq;

    int vectors     = 0;
    int miscompares = 0;

    // Output-link model: bits still owed on the wire, current CNT level, rises seen.
    bit m_bits[$];
    bit m_phase;
    bit m_last;
    int m_rises;
    int in_count;

    cia_serial_port dut (
        .clk      (clk),
        .reset    (reset),
        .clk7_en  (clk7_en),
        .wr       (wr),
        .sdr      (sdr),
        .data_in  (data_in),
        .data_out (data_out),
        .spmode   (spmode),
        .tmra_ovf (tmra_ovf),
        .sp_in    (sp_in),
        .cnt_in   (cnt_in),
        .sp_out   (sp_out),
        .cnt_out  (cnt_out),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One enabled cycle, then a random stretch of disabled cycles with stray underflows.
    task automatic step();
        clk7_en = 1'b1;
        @(posedge clk);
        #1;
        clk7_en  = 1'b0;
        wr       = 1'b0;
        sdr      = 1'b0;
        tmra_ovf = 1'b0;
        reset    = 1'b0;
        repeat ($urandom_range(0, 2)) begin
            tmra_ovf = 1'($urandom);
            @(posedge clk);
            #1;
        end
        tmra_ovf = 1'b0;
    endtask

    task automatic write_sdr(input logic [7:0] d);
        wr      = 1'b1;
        sdr     = 1'b1;
        data_in = d;
    endtask

    task automatic read_check(input string tag, input logic [7:0] exp);
        sdr = 1'b1;
        wr  = 1'b0;
        #1;
        check(tag, data_out, exp);
        sdr = 1'b0;
    endtask

    function automatic void push_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) m_bits.push_back(b[i]);
    endfunction

    function automatic void model_clear();
        m_bits.delete();
        m_phase = 1'b1;
        m_rises = 0;
    endfunction

    // One Timer A underflow after a random timer period, optionally with a CPU write.
    task automatic pulse(input bit with_wr, input logic [7:0] d);
        bit exp_irq;
        exp_irq = 1'b0;
        repeat ($urandom_range(0, 2)) begin
            step();
            check("gap_irq", 8'(irq), 8'h00);
        end
        tmra_ovf = 1'b1;
        if (with_wr) write_sdr(d);
        step();
        if (m_bits.size() == 0) begin
            check("idle_cnt", 8'(cnt_out), 8'h01);
            check("idle_sp", 8'(sp_out), 8'(m_last));
        end else if (m_phase) begin
            m_phase = 1'b0;
            check("cnt_fall", 8'(cnt_out), 8'h00);
            check("sp_fall", 8'(sp_out), 8'(m_bits[0]));
        end else begin
            m_phase = 1'b1;
            m_last  = m_bits.pop_front();
            m_rises++;
            exp_irq = (m_rises % 8) == 0;
            check("cnt_rise", 8'(cnt_out), 8'h01);
            check("sp_rise", 8'(sp_out), 8'(m_last));
        end
        check("pulse_irq", 8'(irq), 8'(exp_irq));
        if (with_wr) push_byte(d);
    endtask

    task automatic pulses(input int n);
        for (int i = 0; i < n; i++) pulse(1'b0, 8'h00);
    endtask

    // Output-mode write from idle: buffer loads on the following enabled cycle.
    task automatic start_byte(input logic [7:0] b);
        write_sdr(b);
        step();
        push_byte(b);
        step();
    endtask

    // One input bit: CNT low then high with SP held.
    task automatic in_bit(input bit b);
        bit exp_irq;
        cnt_in = 1'b0;
        sp_in  = b;
        step();
        check("in_low_irq", 8'(irq), 8'h00);
        cnt_in   = 1'b1;
        tmra_ovf = 1'($urandom);
        step();
        in_count++;
        exp_irq = (in_count % 8) == 0;
        check("in_irq", 8'(irq), 8'(exp_irq));
        check("in_cnt_out", 8'(cnt_out), 8'h01);
        check("in_sp_out", 8'(sp_out), 8'h01);
    endtask

    initial begin
        logic [7:0] b;
        logic [7:0] rx_bytes[3];

        reset    = 1'b1;
        clk7_en  = 1'b0;
        wr       = 1'b0;
        sdr      = 1'b0;
        data_in  = 8'h00;
        spmode   = 1'b0;
        tmra_ovf = 1'b0;
        sp_in    = 1'b0;
        cnt_in   = 1'b1;
        in_count = 0;
        m_last   = 1'b1;
        model_clear();

        // Reset state
        step();
        check("rst_cnt_out", 8'(cnt_out), 8'h01);
        check("rst_sp_out", 8'(sp_out), 8'h01);
        check("rst_irq", 8'(irq), 8'h00);
        read_check("rst_read", 8'h00);
        sdr = 1'b1;
        wr  = 1'b1;
        #1;
        check("write_sel_data_out", data_out, 8'h00);
        sdr = 1'b0;
        wr  = 1'b0;

        // Single byte $A5; an underflow in the load cycle must not move CNT
        spmode = 1'b1;
        step();
        step();
        write_sdr(8'hA5);
        step();
        push_byte(8'hA5);
        tmra_ovf = 1'b1;
        step();
        check("ovf_in_load_cycle", 8'(cnt_out), 8'h01);
        pulses(16);
        pulses(2);
        read_check("a5_read", 8'hA5);

        // Random output bytes
        for (int k = 0; k < 3; k++) begin
            b = 8'($urandom);
            start_byte(b);
            pulses(16);
        end
        pulses(1);

        // Back-to-back $3C then $C3, second written after pulse 4
        start_byte(8'h3C);
        pulses(4);
        write_sdr(8'hC3);
        step();
        push_byte(8'hC3);
        check("b2b_wr_irq", 8'(irq), 8'h00);
        pulses(28);
        pulses(2);

        // Completion collision: write lands on pulse 16 of $80
        start_byte(8'h80);
        pulses(15);
        b = 8'($urandom);
        pulse(1'b1, b);
        step();
        check("coll_load_irq", 8'(irq), 8'h00);
        pulses(16);
        pulses(1);

        // Mode switch abort with a pending byte queued
        start_byte(8'hFF);
        pulses(3);
        write_sdr(8'h55);
        step();
        pulses(3);
        spmode = 1'b0;
        step();
        check("abort_cnt_out", 8'(cnt_out), 8'h01);
        check("abort_sp_out", 8'(sp_out), 8'h01);
        check("abort_irq", 8'(irq), 8'h00);
        model_clear();
        m_last   = 1'b1;
        tmra_ovf = 1'b1;
        step();
        check("input_ovf_cnt", 8'(cnt_out), 8'h01);
        spmode = 1'b1;
        step();
        pulses(3);
        start_byte(8'h01);
        pulses(16);

        // Input mode: random bytes, then $5A, then 7 extra edges
        spmode = 1'b0;
        step();
        in_count = 0;
        rx_bytes[0] = 8'($urandom);
        rx_bytes[1] = 8'($urandom);
        rx_bytes[2] = 8'h5A;
        for (int k = 0; k < 3; k++) begin
            for (int i = 7; i >= 0; i--) in_bit(rx_bytes[k][i]);
            read_check("rx_byte", rx_bytes[k]);
        end
        for (int i = 0; i < 7; i++) in_bit(1'($urandom));
        read_check("rx_partial_keeps", 8'h5A);
        write_sdr(8'h33);
        step();
        read_check("input_mode_write", 8'h33);

        // Reset mid-transfer after pulse 9
        spmode = 1'b1;
        step();
        step();
        model_clear();
        start_byte(8'($urandom_range(1, 255)));
        pulses(9);
        reset = 1'b1;
        step();
        check("midrst_cnt_out", 8'(cnt_out), 8'h01);
        check("midrst_sp_out", 8'(sp_out), 8'h01);
        check("midrst_irq", 8'(irq), 8'h00);
        read_check("midrst_read", 8'h00);
        for (int i = 0; i < 4; i++) begin
            tmra_ovf = 1'b1;
            step();
            check("post_rst_irq", 8'(irq), 8'h00);
            check("post_rst_cnt", 8'(cnt_out), 8'h01);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
